// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus an iterative multiply/divide unit behind a
// valid/ready handshake. States: IDLE (accept), CALC (one bit per cycle for
// DATA_WIDTH cycles), DONE (hold result until consumed).
// Build option: define ALU_MDU_DIV_EN to include the DIV/DIVU/REM/REMU
// datapath. Without it those codes return 0 with single-cycle timing.
module alu_mdu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULH  = 5'b10001;
  localparam logic [4:0] OP_MULHU = 5'b10010;
  localparam logic [4:0] OP_DIV   = 5'b10011;
  localparam logic [4:0] OP_DIVU  = 5'b10100;
  localparam logic [4:0] OP_REM   = 5'b10101;
  localparam logic [4:0] OP_REMU  = 5'b10110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [SHW-1:0]          shamt;
  logic                    is_multi, is_signed, neg_d;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b;
  logic [4:0]              op_q;
  logic [DATA_WIDTH-1:0]   opb;
  logic [2*DATA_WIDTH-1:0] acc, acc_next;
  logic                    neg_q;
  logic [SHW-1:0]          cnt;
  logic                    last;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH-1:0]   hi, lo, mdu_res;
`ifdef ALU_MDU_DIV_EN
  logic [DATA_WIDTH-1:0]   a_q;
  logic                    b_zero;
  logic [DATA_WIDTH:0]     r_shift, diff;
  logic                    ge;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == SHW'(DATA_WIDTH - 1));
  assign shamt     = SrcB[SHW-1:0];

  // Single-cycle ALU result computed straight from the request inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    alu_res = '0;
    case (Operation)
      5'b00000: alu_res = SrcA & SrcB;
      5'b00001: alu_res = SrcA | SrcB;
      5'b00010: alu_res = SrcA + SrcB;
      5'b00011: alu_res = SrcA - SrcB;
      5'b00100: alu_res = SrcA << shamt;
      5'b00101: alu_res = SrcA >> shamt;
      5'b00111: alu_res = $signed(SrcA) >>> shamt;
      5'b01000: alu_res = DATA_WIDTH'(SrcA == SrcB);
      5'b01001: alu_res = DATA_WIDTH'(SrcA != SrcB);
      5'b01010: alu_res = DATA_WIDTH'(SrcA < SrcB);
      5'b01011: alu_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      5'b01100: alu_res = DATA_WIDTH'(SrcA >= SrcB);
      5'b01101: alu_res = SrcA ^ SrcB;
      5'b01110: alu_res = DATA_WIDTH'(1'b1);
      5'b01111: alu_res = DATA_WIDTH'($signed(SrcA) >= $signed(SrcB));
      default:  alu_res = '0;
    endcase
  end

  // Classify the request: iterative or not, and whether operands are signed.
  always_comb begin
    is_multi  = 1'b0;
    is_signed = 1'b0;
    case (Operation)
      OP_MUL, OP_MULHU: is_multi = 1'b1;
      OP_MULH: begin
        is_multi  = 1'b1;
        is_signed = 1'b1;
      end
`ifdef ALU_MDU_DIV_EN
      OP_DIVU, OP_REMU: is_multi = 1'b1;
      OP_DIV, OP_REM: begin
        is_multi  = 1'b1;
        is_signed = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Signed ops iterate on magnitudes; the sign is re-applied at the end.
  // Remainders follow the dividend, products/quotients the operand XOR.
  always_comb begin
    mag_a = (is_signed && SrcA[DATA_WIDTH-1]) ? -SrcA : SrcA;
    mag_b = (is_signed && SrcB[DATA_WIDTH-1]) ? -SrcB : SrcB;
    neg_d = is_signed && ((Operation == OP_REM) ? SrcA[DATA_WIDTH-1]
                                                : (SrcA[DATA_WIDTH-1] ^ SrcB[DATA_WIDTH-1]));
  end

  // One iteration: shift-add multiply or restoring divide on {hi, lo}.
  always_comb begin
    acc_next = acc;
    sum      = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
`ifdef ALU_MDU_DIV_EN
    r_shift  = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
    diff     = r_shift - {1'b0, opb};
    ge       = !diff[DATA_WIDTH];
`endif
    if (op_q == OP_MUL || op_q == OP_MULH || op_q == OP_MULHU) begin
      acc_next = {sum, acc[DATA_WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    end else begin
      acc_next = {ge ? diff[DATA_WIDTH-1:0] : r_shift[DATA_WIDTH-1:0],
                  acc[DATA_WIDTH-2:0], ge};
`endif
    end
  end

  // Final fix-ups applied to the last iteration's value.
  always_comb begin
    hi      = acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
    lo      = acc_next[DATA_WIDTH-1:0];
    mdu_res = '0;
    case (op_q)
      OP_MUL:   mdu_res = lo;
      // High half of a 2W-bit negation: ~hi plus the carry out of ~lo + 1.
      OP_MULH:  mdu_res = neg_q ? (~hi + DATA_WIDTH'(lo == '0)) : hi;
      OP_MULHU: mdu_res = hi;
`ifdef ALU_MDU_DIV_EN
      OP_DIV, OP_DIVU: mdu_res = b_zero ? '1  : (neg_q ? -lo : lo);
      OP_REM, OP_REMU: mdu_res = b_zero ? a_q : (neg_q ? -hi : hi);
`endif
      default: mdu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: handshake in IDLE, fixed-length CALC, hold in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = is_multi ? CALC : DONE;
      CALC:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, iterate in CALC, hold through DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      opb       <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      cnt       <= '0;
      ALUResult <= '0;
`ifdef ALU_MDU_DIV_EN
      a_q       <= '0;
      b_zero    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q  <= Operation;
          opb   <= mag_b;
          acc   <= {{DATA_WIDTH{1'b0}}, mag_a};
          neg_q <= neg_d;
          cnt   <= '0;
`ifdef ALU_MDU_DIV_EN
          a_q    <= SrcA;
          b_zero <= (SrcB == '0);
`endif
          if (!is_multi) ALUResult <= alu_res;
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + SHW'(1);
          if (last) ALUResult <= mdu_res;
        end
        default: ;
      endcase
    end
  end

endmodule
